// File: rtl/vga_timing.sv
// Raster timing generator: walks a configurable h/v raster one pixel per enabled clock
// and presents registered sync, data-enable, coordinates, strobes and a frame counter.
module vga_timing #(
  parameter int frontporch_h = 16,
  parameter int sync_h       = 96,
  parameter int backporch_h  = 48,
  parameter int active_h     = 640,
  parameter int frontporch_v = 10,
  parameter int sync_v       = 2,
  parameter int backporch_v  = 33,
  parameter int active_v     = 480,
  parameter bit sync_pol     = 1'b0,
  localparam int total_h = active_h + frontporch_h + sync_h + backporch_h,
  localparam int total_v = active_v + frontporch_v + sync_v + backporch_v,
  localparam int HW = (total_h > 1) ? $clog2(total_h) : 1,
  localparam int VW = (total_v > 1) ? $clog2(total_v) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam logic [HW-1:0] H_ACT  = HW'(active_h);
  localparam logic [HW-1:0] HS_BEG = HW'(active_h + frontporch_h);
  localparam logic [HW-1:0] HS_END = HW'(active_h + frontporch_h + sync_h);
  localparam logic [HW-1:0] H_LAST = HW'(total_h - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(active_v);
  localparam logic [VW-1:0] VS_BEG = VW'(active_v + frontporch_v);
  localparam logic [VW-1:0] VS_END = VW'(active_v + frontporch_v + sync_v);
  localparam logic [VW-1:0] V_LAST = VW'(total_v - 1);

  logic [HW-1:0] px_p0;
  logic [VW-1:0] py_p0;
  logic          first_p0;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          de_nxt;
  logic          ls_nxt;
  logic          fs_nxt;

  // Stage p0: decode the raster pointer into the values to present at the next enabled edge
  always_comb begin
    hs_nxt = ~sync_pol;
    vs_nxt = ~sync_pol;
    if (px_p0 >= HS_BEG && px_p0 < HS_END) hs_nxt = sync_pol;
    if (py_p0 >= VS_BEG && py_p0 < VS_END) vs_nxt = sync_pol;
    de_nxt = (px_p0 < H_ACT) && (py_p0 < V_ACT);
    ls_nxt = (px_p0 == '0);
    fs_nxt = (px_p0 == '0) && (py_p0 == '0);
  end

  // Stage p1: registered outputs, pointer advance and frame counting
  always_ff @(posedge clk) begin
    if (rst) begin
      px_p0       <= '0;
      py_p0       <= '0;
      first_p0    <= 1'b1;
      hsync       <= ~sync_pol;
      vsync       <= ~sync_pol;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else if (ce) begin
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      de          <= de_nxt;
      x           <= px_p0;
      y           <= py_p0;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      // The first frame after reset keeps frame_cnt at 0; later frame starts count.
      if (fs_nxt) begin
        if (first_p0) first_p0 <= 1'b0;
        else          frame_cnt <= frame_cnt + 8'd1;
      end
      if (px_p0 == H_LAST) begin
        px_p0 <= '0;
        py_p0 <= (py_p0 == V_LAST) ? '0 : py_p0 + VW'(1);
      end else begin
        px_p0 <= px_p0 + HW'(1);
      end
    end
  end

endmodule
